// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL power-up sequencer.
package pll_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CP_ON   = 3'd1,
    ST_VCO_ON  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam int DEF_CW        = 10;
  localparam int DEF_WIN       = 256;
  localparam int DEF_T_CP      = 64;
  localparam int DEF_T_SETTLE  = 1024;
  localparam int DEF_LOCK_HITS = 4;
  localparam int DEF_MAX_RETRY = 8;
endpackage

// File: rtl/pll_seq_ctrl_if.sv
// Control/status bundle between the PLL sequencer and the pad/GPIO side.
interface pll_seq_ctrl_if #(parameter int CW = 10);
  logic          start;
  logic [3:0]    b_cfg;
  logic [CW-1:0] exp_cnt;
  logic [3:0]    tol;
  logic          fb_div;
  logic          enb_cp;
  logic          enb_vco;
  logic [3:0]    b_sel;
  logic          locked;
  logic          fault;
  logic [2:0]    state_o;

  // master = system side driving config, slave = the sequencer
  modport master (
    output start, b_cfg, exp_cnt, tol, fb_div,
    input  enb_cp, enb_vco, b_sel, locked, fault, state_o
  );
  modport slave (
    input  start, b_cfg, exp_cnt, tol, fb_div,
    output enb_cp, enb_vco, b_sel, locked, fault, state_o
  );
endinterface

// File: rtl/pll_fb_sync.sv
// Feedback synchronizer, rising-edge detector and saturating edge counter.
module pll_fb_sync
  import pll_ctrl_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          ref_clk,
  input  logic          porb,
  input  logic          fb_div,
  input  logic          clr,
  output logic [CW-1:0] cnt_win
);
  logic [2:0]    sync_pipe;
  logic          edge_p;
  logic [CW-1:0] cnt;

  always_ff @(posedge ref_clk or negedge porb)
    if (!porb) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[1:0], fb_div};

  assign edge_p = sync_pipe[1] & ~sync_pipe[2];

  // cnt_win already includes this cycle's pulse so the window compare sees it
  assign cnt_win = (edge_p && (cnt != '1)) ? cnt + 1'b1 : cnt;

  always_ff @(posedge ref_clk or negedge porb)
    if (!porb)    cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_win;
endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL enable sequencer and windowed lock monitor on ref_clk.
module pll_seq_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter int WIN       = DEF_WIN,
  parameter int T_CP      = DEF_T_CP,
  parameter int T_SETTLE  = DEF_T_SETTLE,
  parameter int LOCK_HITS = DEF_LOCK_HITS,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic          ref_clk,
  input  logic          porb,
  pll_seq_ctrl_if.slave bus
);
  localparam int TMAX = (T_SETTLE > T_CP) ? ((T_SETTLE > WIN) ? T_SETTLE : WIN)
                                          : ((T_CP > WIN) ? T_CP : WIN);
  localparam int TW   = $clog2(TMAX);
  localparam int HW   = $clog2(LOCK_HITS + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [HW-1:0] hits, hits_nxt;
  logic [RW-1:0] retries, retries_nxt;
  logic          enb_cp, enb_vco, locked, fault;
  logic          enb_cp_nxt, enb_vco_nxt, locked_nxt, fault_nxt;
  logic [3:0]    b_sel, b_sel_nxt;
  logic [CW-1:0] win_cnt;
  logic [CW:0]   dev;
  logic          in_win, tmr_last, win_end, hit, timed, cnt_clr;

  pll_fb_sync #(.CW(CW)) u_fb_sync (
    .ref_clk (ref_clk),
    .porb    (porb),
    .fb_div  (bus.fb_div),
    .clr     (cnt_clr),
    .cnt_win (win_cnt)
  );

  assign in_win = (state == ST_MEASURE) || (state == ST_LOCKED);
  assign timed  = in_win || (state == ST_CP_ON) || (state == ST_VCO_ON);

  always_comb begin
    tmr_last = 1'b0;
    case (state)
      ST_CP_ON:             tmr_last = (tmr == TW'(T_CP - 1));
      ST_VCO_ON:            tmr_last = (tmr == TW'(T_SETTLE - 1));
      ST_MEASURE, ST_LOCKED: tmr_last = (tmr == TW'(WIN - 1));
      default:              tmr_last = 1'b0;
    endcase
  end

  assign win_end = in_win && tmr_last;
  assign dev     = (win_cnt >= bus.exp_cnt) ? ({1'b0, win_cnt} - {1'b0, bus.exp_cnt})
                                            : ({1'b0, bus.exp_cnt} - {1'b0, win_cnt});
  assign hit     = (dev <= (CW+1)'(bus.tol));

  // next state, hit/retry bookkeeping
  always_comb begin
    state_nxt   = state;
    hits_nxt    = hits;
    retries_nxt = retries;
    if (state != ST_IDLE && !bus.start) begin
      state_nxt   = ST_IDLE;
      hits_nxt    = '0;
      retries_nxt = '0;
    end else begin
      case (state)
        ST_IDLE:   if (bus.start) state_nxt = ST_CP_ON;
        ST_CP_ON:  if (tmr_last)  state_nxt = ST_VCO_ON;
        ST_VCO_ON: if (tmr_last) begin
          state_nxt   = ST_MEASURE;
          hits_nxt    = '0;
          retries_nxt = '0;
        end
        ST_MEASURE: if (win_end) begin
          if (hit) begin
            hits_nxt    = hits + 1'b1;
            retries_nxt = '0;
            if (hits_nxt == HW'(LOCK_HITS)) state_nxt = ST_LOCKED;
          end else begin
            hits_nxt    = '0;
            retries_nxt = retries + 1'b1;
            if (retries_nxt == RW'(MAX_RETRY)) state_nxt = ST_FAULT;
          end
        end
        ST_LOCKED: if (win_end && !hit) begin
          state_nxt   = ST_MEASURE;
          hits_nxt    = '0;
          retries_nxt = '0;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // one timer serves the CP/VCO delays and the measurement window
  assign tmr_nxt = (!timed || tmr_last || (state_nxt != state)) ? '0 : tmr + 1'b1;
  assign cnt_clr = !in_win || win_end || (state_nxt != state);

  // outputs decoded from the next state so they register alongside it
  always_comb begin
    enb_cp_nxt  = !(state_nxt inside {ST_CP_ON, ST_VCO_ON, ST_MEASURE, ST_LOCKED});
    enb_vco_nxt = !(state_nxt inside {ST_VCO_ON, ST_MEASURE, ST_LOCKED});
    locked_nxt  = (state_nxt == ST_LOCKED);
    fault_nxt   = (state_nxt == ST_FAULT);
    b_sel_nxt   = b_sel;
    if (state == ST_IDLE && state_nxt == ST_CP_ON) b_sel_nxt = bus.b_cfg;
  end

  always_ff @(posedge ref_clk or negedge porb)
    if (!porb) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      hits    <= '0;
      retries <= '0;
      enb_cp  <= 1'b1;
      enb_vco <= 1'b1;
      locked  <= 1'b0;
      fault   <= 1'b0;
      b_sel   <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      hits    <= hits_nxt;
      retries <= retries_nxt;
      enb_cp  <= enb_cp_nxt;
      enb_vco <= enb_vco_nxt;
      locked  <= locked_nxt;
      fault   <= fault_nxt;
      b_sel   <= b_sel_nxt;
    end

  assign bus.enb_cp  = enb_cp;
  assign bus.enb_vco = enb_vco;
  assign bus.locked  = locked;
  assign bus.fault   = fault;
  assign bus.b_sel   = b_sel;
  assign bus.state_o = state;
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl: power-up timing, lock, loss of lock, fault, async reset.
module tb_pll_seq_ctrl;
  import pll_ctrl_pkg::*;
  localparam int CW = 10;

  logic ref_clk = 1'b0;
  logic porb    = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   ph      = 0;
  int   k_req   = 32;
  int   k_cur   = 32;
  int   s_edge, e_edge;

  pll_seq_ctrl_if #(.CW(CW)) bus();

  pll_seq_ctrl #(.CW(CW)) dut (
    .ref_clk (ref_clk),
    .porb    (porb),
    .bus     (bus)
  );

  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) cyc <= cyc + 1;

  // k rising edges per 256-cycle period; phase chosen so each window sees one k
  always @(negedge ref_clk) begin
    int p;
    p = ((cyc - ph) % 256 + 256) % 256;
    if (p == 0) k_cur = k_req;
    bus.fb_div = (k_cur != 0) && (((p * k_cur) % 256) < 128);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_edge(input int t);
    while (cyc < t) @(negedge ref_clk);
  endtask

  // start edge S is the next posedge; measurement starts at S+64+1024
  task automatic power_up(input logic [3:0] b);
    bus.b_cfg = b;
    bus.start = 1'b1;
    s_edge    = cyc + 1;
    e_edge    = s_edge + 1088;
    ph        = e_edge - 2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.b_cfg   = 4'h0;
    bus.exp_cnt = 10'd32;
    bus.tol     = 4'd1;
    repeat (5) @(negedge ref_clk);
    chk("rst_enb_cp",  bus.enb_cp,  1);
    chk("rst_enb_vco", bus.enb_vco, 1);
    chk("rst_b_sel",   bus.b_sel,   0);
    chk("rst_locked",  bus.locked,  0);
    chk("rst_fault",   bus.fault,   0);
    chk("rst_state",   bus.state_o, 0);
    porb = 1'b1;
    repeat (3) @(negedge ref_clk);
    chk("idle_state",  bus.state_o, 0);
    chk("idle_enb_cp", bus.enb_cp,  1);

    // power-up sequence, 32 edges per window
    power_up(4'hA);
    wait_edge(s_edge);
    chk("cp_state",    bus.state_o, 1);
    chk("cp_b_sel",    bus.b_sel,   4'hA);
    chk("cp_enb_cp",   bus.enb_cp,  0);
    chk("cp_enb_vco",  bus.enb_vco, 1);
    bus.b_cfg = 4'h5;
    wait_edge(s_edge + 63);
    chk("cp_last_vco", bus.enb_vco, 1);
    wait_edge(s_edge + 64);
    chk("vco_enb_vco", bus.enb_vco, 0);
    chk("vco_state",   bus.state_o, 2);
    chk("vco_b_hold",  bus.b_sel,   4'hA);
    wait_edge(e_edge - 1);
    chk("settle_last", bus.state_o, 2);
    wait_edge(e_edge);
    chk("meas_state",  bus.state_o, 3);
    wait_edge(e_edge + 1023);
    chk("pre_lock",    bus.locked,  0);
    wait_edge(e_edge + 1024);
    chk("lock32",      bus.locked,  1);
    chk("lock32_st",   bus.state_o, 4);

    // 40 edges in window 5 drops lock; 32 again from window 6
    k_req = 40;
    wait_edge(e_edge + 1300);
    k_req = 32;
    wait_edge(e_edge + 1535);
    chk("lost_pre",    bus.locked,  1);
    wait_edge(e_edge + 1536);
    chk("lost_lock",   bus.locked,  0);
    chk("lost_state",  bus.state_o, 3);
    chk("lost_enb_cp", bus.enb_cp,  0);
    chk("lost_enb_vco",bus.enb_vco, 0);
    wait_edge(e_edge + 2559);
    chk("relock_pre",  bus.locked,  0);
    wait_edge(e_edge + 2560);
    chk("relock",      bus.locked,  1);

    // shut down, then 33 edges per window with tol=1
    bus.start = 1'b0;
    wait_edge(cyc + 1);
    chk("stop_state",  bus.state_o, 0);
    chk("stop_locked", bus.locked,  0);
    chk("stop_enb_cp", bus.enb_cp,  1);
    chk("stop_b_hold", bus.b_sel,   4'hA);
    k_req = 33;
    power_up(4'h3);
    wait_edge(s_edge);
    chk("r33_b_sel",   bus.b_sel,   4'h3);
    wait_edge(e_edge + 1023);
    chk("r33_pre",     bus.locked,  0);
    wait_edge(e_edge + 1024);
    chk("lock33",      bus.locked,  1);

    // no feedback at all: fault after 8 windows
    bus.start = 1'b0;
    wait_edge(cyc + 1);
    k_req = 0;
    power_up(4'h6);
    wait_edge(e_edge + 2047);
    chk("flt_pre_st",  bus.state_o, 3);
    chk("flt_pre",     bus.fault,   0);
    wait_edge(e_edge + 2048);
    chk("flt_state",   bus.state_o, 5);
    chk("flt_fault",   bus.fault,   1);
    chk("flt_enb_cp",  bus.enb_cp,  1);
    chk("flt_enb_vco", bus.enb_vco, 1);
    chk("flt_b_sel",   bus.b_sel,   4'h6);
    wait_edge(e_edge + 2100);
    chk("flt_hold",    bus.state_o, 5);
    bus.start = 1'b0;
    wait_edge(cyc + 1);
    chk("flt_idle",    bus.state_o, 0);
    chk("flt_clear",   bus.fault,   0);

    // restart and lock, then async reset between edges
    k_req = 32;
    power_up(4'h9);
    wait_edge(s_edge);
    chk("rs_state",    bus.state_o, 1);
    chk("rs_enb_cp",   bus.enb_cp,  0);
    wait_edge(e_edge + 1024);
    chk("rs_locked",   bus.locked,  1);
    #2 porb = 1'b0;
    #1;
    chk("ar_enb_cp",   bus.enb_cp,  1);
    chk("ar_enb_vco",  bus.enb_vco, 1);
    chk("ar_locked",   bus.locked,  0);
    chk("ar_b_sel",    bus.b_sel,   0);
    chk("ar_state",    bus.state_o, 0);
    bus.start = 1'b0;
    @(negedge ref_clk);
    porb = 1'b1;
    repeat (4) @(negedge ref_clk);
    chk("ar_wait",     bus.state_o, 0);
    power_up(4'hC);
    wait_edge(s_edge);
    chk("ar_restart",  bus.state_o, 1);
    chk("ar_b_new",    bus.b_sel,   4'hC);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
- Power-up sequencer and lock monitor for the analog PLL macro. Runs on the reference clock after power-on reset.
- Drives the PLL active-low enables (ENb_CP, ENb_VCO) in order and applies the divider code B[3:0].
- Measures the divided PLL feedback against an expected count per window and reports locked / fault status to GPIO or the padframe.

Parameters:
CW, 10, width of feedback edge counter and expected-count input
WIN, 256, measurement window length in ref_clk cycles
T_CP, 64, ref_clk cycles between charge-pump enable and VCO enable
T_SETTLE, 1024, ref_clk cycles after VCO enable before first measurement
LOCK_HITS, 4, consecutive in-tolerance windows required to declare lock
MAX_RETRY, 8, consecutive out-of-tolerance windows before FAULT (pre-lock only)

Ports:
ref_clk  input  1  sole clock (PLL reference clock)
porb  input  1  asynchronous active-low reset (from POR porb_h)
start  input  1  level; 1 = run PLL, 0 = shut down
b_cfg  input  4  divider code, sampled on IDLE->CP_ON
exp_cnt  input  CW  expected feedback rising edges per window
tol  input  4  allowed |count-exp_cnt| deviation
fb_div  input  1  PLL output divided externally; asynchronous, toggle rate < ref_clk/4
enb_cp  output  1  to PLL ENb_CP, active-low
enb_vco  output  1  to PLL ENb_VCO, active-low
b_sel  output  4  to PLL B[3:0]
locked  output  1  lock indicator
fault  output  1  lock-acquisition failure
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset (porb=0, async): state=IDLE, enb_cp=1, enb_vco=1, b_sel=0, locked=0, fault=0, all counters 0, synchronizer flops 0. Reset mid-operation aborts immediately to these values.
- fb_div passes through a 2-flop synchronizer and a rising-edge detector (third flop). Edge pulse latency is 3 ref_clk cycles. Edge count saturates at 2^CW-1.
- States: IDLE=0, CP_ON=1, VCO_ON=2, MEASURE=3, LOCKED=4, FAULT=5.
- IDLE: enables high. If start=1, latch b_sel<=b_cfg and go to CP_ON.
- CP_ON: enb_cp=0. After T_CP cycles (timer counts 0..T_CP-1), go to VCO_ON.
- VCO_ON: enb_cp=0, enb_vco=0. After T_SETTLE cycles, go to MEASURE, with window counter, edge count, hits and retries cleared.
- Window rule (MEASURE and LOCKED): count edges for exactly WIN cycles. On the last cycle, include that cycle's edge pulse, then compare.
  - hit = |cnt - exp_cnt| <= tol, computed unsigned at CW+1 bits.
  - Edge count and window counter restart the next cycle with no gap cycle.
- MEASURE:
  - On hit: hits++, retries=0. When hits reaches LOCK_HITS, go to LOCKED and set locked=1 in the same cycle as the state change.
  - On miss: hits=0, retries++. When retries reaches MAX_RETRY, go to FAULT.
- LOCKED: locked=1. A miss clears locked and returns to MEASURE with hits=0, retries=0; the enables stay asserted. Hits in LOCKED change nothing.
- FAULT: enb_cp=1, enb_vco=1, fault=1, b_sel held. Stays in FAULT while start=1.
- start=0 in any non-IDLE state: next cycle goes to IDLE with enables=1, locked=0, fault=0 and counters cleared. b_sel holds its last value.
- b_cfg changes outside IDLE are ignored.
- All outputs are registered; no combinational paths from input to output.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - state enum constants (3-bit encodings above)
  - default timing constants T_CP, T_SETTLE, WIN
- One natural sub-module: pll_fb_sync. It contains the 2-flop synchronizer, the edge detector and a saturating CW-bit edge counter with a clear input.
- The FSM, timers and compare logic live in pll_seq_ctrl.

Test Plan:
- Reset and idle: porb low for 5 cycles with start=0 -> enb_cp=1, enb_vco=1, b_sel=0, locked=0, fault=0, state_o=0.
- Power-up sequence: start=1 with b_cfg=4'hA.
  - Next cycle: b_sel=A, enb_cp=0.
  - enb_vco falls 64 cycles later.
  - MEASURE entered 1024 cycles after that.
- Lock acquire: WIN=256, exp_cnt=32, tol=1, fb_div square wave with period 8 ref cycles (32 edges/window).
  - locked=1 at the end of the 4th window.
  - Repeat with period giving 33 edges: still locks.
- Lost lock: after lock, change fb_div to 40 edges/window -> locked=0 at that window's end, state_o=3, enables remain 0. Restore 32 -> relock after 4 windows.
- Fault: fb_div held constant (0 edges, exp_cnt=32) -> FAULT after 8 windows with fault=1 and enables=1. Drop start -> IDLE, fault=0. Raise start again -> sequence restarts.
- Async reset mid-run: assert porb low in LOCKED, between clock edges -> outputs go to reset values immediately, without a clock edge. After release, the block waits in IDLE until start rises again.
